// File: rtl/trivium_pkg.sv
// Shared Trivium constants, tap positions, FSM encoding and the key/IV load mapping.
package trivium_pkg;

    localparam int unsigned TRIV_STATE_W = 288;
    localparam int unsigned TRIV_KEY_W   = 80;
    localparam int unsigned TRIV_IV_W    = 80;

    // r[i] holds s(i+1)
    localparam int unsigned TAP_T1_OUT  = 65;
    localparam int unsigned TAP_T1_LAST = 92;
    localparam int unsigned TAP_T1_AND0 = 90;
    localparam int unsigned TAP_T1_AND1 = 91;
    localparam int unsigned TAP_T1_FB   = 170;

    localparam int unsigned TAP_T2_OUT  = 161;
    localparam int unsigned TAP_T2_LAST = 176;
    localparam int unsigned TAP_T2_AND0 = 174;
    localparam int unsigned TAP_T2_AND1 = 175;
    localparam int unsigned TAP_T2_FB   = 263;

    localparam int unsigned TAP_T3_OUT  = 242;
    localparam int unsigned TAP_T3_LAST = 287;
    localparam int unsigned TAP_T3_AND0 = 285;
    localparam int unsigned TAP_T3_AND1 = 286;
    localparam int unsigned TAP_T3_FB   = 68;

    typedef enum logic [1:0] {
        TRIV_IDLE,
        TRIV_INIT,
        TRIV_RUN
    } triv_state_e;

    function automatic logic [TRIV_STATE_W-1:0] triv_load(
        input logic [TRIV_KEY_W-1:0] key,
        input logic [TRIV_IV_W-1:0]  iv
    );
        logic [TRIV_STATE_W-1:0] s;
        s            = '0;
        s[79:0]      = key;
        s[172:93]    = iv;
        s[287:285]   = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round_unroll.sv
// W Trivium rounds unrolled combinationally; z[j] is the output bit of round j.
module trivium_round_unroll
    import trivium_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic [TRIV_STATE_W-1:0] state_in,
    output logic [TRIV_STATE_W-1:0] state_out,
    output logic [W-1:0]            z
);

    logic [TRIV_STATE_W-1:0] s;
    logic t1, t2, t3;

    always_comb begin
        s  = state_in;
        z  = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int unsigned j = 0; j < W; j++) begin
            t1   = s[TAP_T1_OUT] ^ s[TAP_T1_LAST];
            t2   = s[TAP_T2_OUT] ^ s[TAP_T2_LAST];
            t3   = s[TAP_T3_OUT] ^ s[TAP_T3_LAST];
            z[j] = t1 ^ t2 ^ t3;
            t1   = t1 ^ (s[TAP_T1_AND0] & s[TAP_T1_AND1]) ^ s[TAP_T1_FB];
            t2   = t2 ^ (s[TAP_T2_AND0] & s[TAP_T2_AND1]) ^ s[TAP_T2_FB];
            t3   = t3 ^ (s[TAP_T3_AND0] & s[TAP_T3_AND1]) ^ s[TAP_T3_FB];
            s    = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        state_out = s;
    end

endmodule

// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator with valid/ready output; TRIVIUM_XOR_EN adds a din stream XORed into ks_data.
module trivium_stream_gen
    import trivium_pkg::*;
#(
    parameter int unsigned W           = 1,
    parameter int unsigned INIT_ROUNDS = 1152
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TRIV_KEY_W-1:0] key,
    input  logic [TRIV_IV_W-1:0]  iv,
    input  logic                  load,
    output logic                  busy,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic [W-1:0]          ks_data
`ifdef TRIVIUM_XOR_EN
    ,
    input  logic [W-1:0]          din,
    input  logic                  din_valid,
    output logic                  din_ready
`endif
);

    localparam int unsigned INIT_CLKS = INIT_ROUNDS / W;
    localparam int unsigned CNT_W     = $clog2(INIT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CLKS - 1);

    triv_state_e state, state_next;

    logic [TRIV_STATE_W-1:0] r, step_in, step_out;
    logic [W-1:0]            z, word;
    logic [CNT_W-1:0]        cnt;
    logic                    slot_free, init_done, advance, emit;

    assign slot_free = !ks_valid || ks_ready;
    assign init_done = (cnt == CNT_LAST);

    // The load edge already runs the first W warm-up rounds on the fresh state, so
    // the first word is registered on the edge right after busy's last cycle.
    always_comb step_in = load ? triv_load(key, iv) : r;

    trivium_round_unroll #(.W(W)) u_round (
        .state_in  (step_in),
        .state_out (step_out),
        .z         (z)
    );

`ifdef TRIVIUM_XOR_EN
    assign word = z ^ din;
`else
    assign word = z;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= TRIV_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TRIV_IDLE: state_next = TRIV_IDLE;
            TRIV_INIT: if (init_done) state_next = TRIV_RUN;
            TRIV_RUN:  state_next = TRIV_RUN;
            default:   state_next = TRIV_IDLE;
        endcase
        if (load) state_next = TRIV_INIT;
    end

    always_comb begin
        busy    = (state == TRIV_INIT);
        advance = 1'b0;
        emit    = 1'b0;
`ifdef TRIVIUM_XOR_EN
        din_ready = 1'b0;
        case (state)
            TRIV_INIT: advance = !init_done;
            TRIV_RUN: begin
                din_ready = slot_free;
                advance   = slot_free && din_valid;
                emit      = advance;
            end
            default: ;
        endcase
`else
        case (state)
            TRIV_INIT: begin
                advance = !init_done;
                emit    = init_done;
                if (init_done) advance = 1'b1;
            end
            TRIV_RUN: begin
                advance = slot_free;
                emit    = slot_free;
            end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= '0;
            cnt      <= '0;
            ks_valid <= 1'b0;
            ks_data  <= '0;
        end else if (load) begin
            r        <= step_out;
            cnt      <= '0;
            ks_valid <= 1'b0;
        end else begin
            if (advance) r <= step_out;
            if (state == TRIV_INIT) cnt <= cnt + 1'b1;
            if (emit) begin
                ks_data  <= word;
                ks_valid <= 1'b1;
            end else if (ks_ready) begin
                ks_valid <= 1'b0;
            end
        end
    end

endmodule
